// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 codes,
// FSM states and W-stage fault codes.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane placement for stores, lane select plus extension
// for loads, and detection of misaligned or illegal accesses.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        addr_bad;

  always_comb begin
    be      = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (funct3)
      F3_SB: begin
        be      = 4'b0001 << addr;
        wdata_o = {4{wdata[7:0]}};
      end
      F3_SH: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata[15:0]}};
      end
      F3_SW: begin
        be      = 4'b1111;
        wdata_o = wdata;
      end
      default: begin
        be      = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    byte_sel  = rdata[{addr, 3'b000} +: 8];
    half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_ext = rdata;
      F3_LBU:  rdata_ext = {24'h00_0000, byte_sel};
      F3_LHU:  rdata_ext = {16'h0000, half_sel};
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

  // Width comes from funct3[1:0]; 01 is half and 10 is word for loads and stores alike.
  always_comb begin
    illegal  = (is_load & is_store)
             | (is_load & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
             | (is_store & (funct3 >= 3'b011));
    addr_bad = ((funct3[1:0] == 2'b01) & addr[0])
             | ((funct3[1:0] == 2'b10) & (addr != 2'b00));
    misalign = (is_load | is_store) & (illegal | addr_bad);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage and M->W pipeline register: req/ack data bus handshake with
// wait-state stalling, timeout abort and fault reporting into W.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic [1:0]  FaultW
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  lsu_state_t  state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        memop, fault_align, aborting, ack_ok;
  logic [1:0]  fault_code;
  logic [31:0] rdata_ext;

  lsu_align u_align (
    .addr      (ALUResultM[1:0]),
    .funct3    (Funct3M),
    .is_load   (MemReadM),
    .is_store  (MemWriteM),
    .wdata     (WriteDataM),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata_o   (dmem_wdata),
    .rdata_ext (rdata_ext),
    .misalign  (fault_align)
  );

  // Abort uses the raw ack so that an ack at the limit still completes normally.
  always_comb begin
    memop      = MemReadM | MemWriteM;
    aborting   = (state == ST_WAIT) & ~dmem_ack & (cnt == MAX_CNT);
    dmem_req   = memop & ~fault_align & ~aborting & ~reset;
    ack_ok     = dmem_req & dmem_ack;
    StallM     = dmem_req & ~dmem_ack;
    dmem_we    = MemWriteM;
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    if (fault_align) begin
      fault_code = FAULT_ALIGN;
    end else if (aborting) begin
      fault_code = FAULT_TIMEOUT;
    end else begin
      fault_code = FAULT_NONE;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (StallM) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (StallM) begin
          cnt_next = cnt + 8'd1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Stalled cycles push a bubble into W while the data fields hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResultW <= 32'h0000_0000;
      ReadDataW  <= 32'h0000_0000;
      PCPlus4W   <= 32'h0000_0000;
      RdW        <= 5'd0;
      ResultSrcW <= 2'b00;
      RegWriteW  <= 1'b0;
      FaultW     <= FAULT_NONE;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      FaultW    <= FAULT_NONE;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= (ack_ok & MemReadM) ? rdata_ext : 32'h0000_0000;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      ResultSrcW <= ResultSrcM;
      RegWriteW  <= RegWriteM & (fault_code == FAULT_NONE);
      FaultW     <= fault_code;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (MAX_WAIT=4): stores, loads, wait states,
// faults, timeout, reset during a wait and back-to-back loads.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, RegWriteM, dmem_ack;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic        StallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW, FaultW;
  logic        RegWriteW;

  int checks   = 0;
  int failures = 0;

  mem_stage_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .FaultW(FaultW)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rdst, input logic rw,
                        input logic ack, input logic [31:0] rdata);
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rdst;
    PCPlus4M   = addr + 32'd4;
    RegWriteM  = rw;
    ResultSrcM = rd ? 2'b01 : 2'b00;
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  task automatic step_w();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0);
    #1;
    check_eq("reset_req", 32'(dmem_req), 32'd0);
    step_w();
    step_w();
    check_eq("reset_regwrite", 32'(RegWriteW), 32'd0);
    check_eq("reset_alures", ALUResultW, 32'h0);
    check_eq("reset_fault", 32'(FaultW), 32'd0);

    // SW, zero wait
    @(negedge clk);
    reset = 1'b0;
    set_op(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq("sw_be", 32'(dmem_be), 32'hF);
    check_eq("sw_req", 32'(dmem_req), 32'd1);
    check_eq("sw_we", 32'(dmem_we), 32'd1);
    check_eq("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check_eq("sw_stall", 32'(StallM), 32'd0);
    step_w();
    check_eq("sw_regwrite", 32'(RegWriteW), 32'd0);
    check_eq("sw_fault", 32'(FaultW), 32'd0);
    check_eq("sw_aluw", ALUResultW, 32'h0000_0100);

    // LB @0x103 with three wait states
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b0, 32'h80FF_FF7F);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lb_wait_stall", 32'(StallM), 32'd1);
      check_eq("lb_wait_addr", dmem_addr, 32'h0000_0100);
      step_w();
      check_eq("lb_wait_bubble", 32'(RegWriteW), 32'd0);
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    #1;
    check_eq("lb_ack_stall", 32'(StallM), 32'd0);
    step_w();
    check_eq("lb_data", ReadDataW, 32'hFFFF_FF80);
    check_eq("lb_regwrite", 32'(RegWriteW), 32'd1);
    check_eq("lb_rd", 32'(RdW), 32'd5);

    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 1'b1, 32'h80FF_FF7F);
    step_w();
    check_eq("lbu_data", ReadDataW, 32'h0000_0080);

    // SH and misaligned / illegal loads
    @(negedge clk);
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 5'd0, 1'b0, 1'b1, 32'h0);
    #1;
    check_eq("sh_be", 32'(dmem_be), 32'hC);
    check_eq("sh_wdata", dmem_wdata, 32'h1234_1234);
    step_w();

    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 1'b1, 32'h0);
    #1;
    check_eq("lh_mis_req", 32'(dmem_req), 32'd0);
    check_eq("lh_mis_stall", 32'(StallM), 32'd0);
    step_w();
    check_eq("lh_mis_fault", 32'(FaultW), 32'd1);
    check_eq("lh_mis_regwrite", 32'(RegWriteW), 32'd0);

    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 32'h0);
    step_w();
    check_eq("ld_illegal_fault", 32'(FaultW), 32'd1);

    // timeout: four stalled cycles then abort
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("to_stall", 32'(StallM), 32'd1);
      step_w();
      @(negedge clk);
    end
    #1;
    check_eq("to_release", 32'(StallM), 32'd0);
    check_eq("to_req", 32'(dmem_req), 32'd0);
    step_w();
    check_eq("to_fault", 32'(FaultW), 32'd2);
    check_eq("to_regwrite", 32'(RegWriteW), 32'd0);

    // ack exactly at the limit completes
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 5'd9, 1'b1, 1'b0, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      step_w();
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    #1;
    check_eq("lim_req", 32'(dmem_req), 32'd1);
    check_eq("lim_stall", 32'(StallM), 32'd0);
    step_w();
    check_eq("lim_data", ReadDataW, 32'h1122_3344);
    check_eq("lim_fault", 32'(FaultW), 32'd0);
    check_eq("lim_regwrite", 32'(RegWriteW), 32'd1);

    // reset while waiting
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0208, 32'h0, 5'd10, 1'b1, 1'b0, 32'h0);
    step_w();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_wait_req", 32'(dmem_req), 32'd0);
    check_eq("rst_wait_stall", 32'(StallM), 32'd0);
    check_eq("rst_wait_alu", ALUResultW, 32'h0);
    check_eq("rst_wait_rd", 32'(RdW), 32'd0);
    check_eq("rst_wait_fault", 32'(FaultW), 32'd0);
    step_w();
    @(negedge clk);
    reset = 1'b0;
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd1, 1'b1, 1'b0, 32'h0);
    // state must restart at IDLE: exactly four stalls before abort
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rst_idle_stall", 32'(StallM), 32'd1);
      step_w();
      @(negedge clk);
    end
    #1;
    check_eq("rst_idle_abort", 32'(StallM), 32'd0);
    step_w();

    // back-to-back zero-wait LW
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd1, 1'b1, 1'b1, 32'hAAAA_0001);
    step_w();
    check_eq("b2b1_data", ReadDataW, 32'hAAAA_0001);
    check_eq("b2b1_rd", 32'(RdW), 32'd1);
    check_eq("b2b1_pc4", PCPlus4W, 32'h0000_0304);
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 5'd2, 1'b1, 1'b1, 32'hBBBB_0002);
    step_w();
    check_eq("b2b2_data", ReadDataW, 32'hBBBB_0002);
    check_eq("b2b2_rd", 32'(RdW), 32'd2);
    check_eq("b2b2_regwrite", 32'(RegWriteW), 32'd1);
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_0050, 32'h0, 5'd4, 1'b1, 1'b1, 32'hCCCC_CCCC);
    step_w();
    check_eq("alu_nodata", ReadDataW, 32'h0);
    check_eq("alu_regwrite", 32'(RegWriteW), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
